ijtag_tdr_access_driver: RTL and testbench
==========================================

Name:
ijtag_tdr_access_driver

Overview:
- IJTAG initiator that drives one TDR segment, such as the 20-bit trim/fuse override TDRs, from a parallel request interface.
- Sequences capture → shift → update on the ijtag_* control lines.
- Drives new data in on ijtag_si and collects the captured read-back from ijtag_so.
- Sits between the on-die test/fuse controller and the TDR chain, replacing tester-driven iJTAG access for in-system override programming.

Parameters:
- TDR_LEN, 20, number of TDR bits shifted per access (≥2).
- CNT_W, $clog2(TDR_LEN+1), width of the shift-bit counter.

Ports:
- ijtag_tck  input  1  IJTAG clock; all driver flops are posedge.
- ijtag_reset  input  1  reset, asynchronous, active-low.
- req_valid  input  1  access request.
- req_ready  output  1  driver idle, request accepted at posedge when req_valid & req_ready.
- req_wdata  input  TDR_LEN  value to load into the TDR; bit 0 lands in TDR bit 0.
- req_read_only  input  1  1 = capture+shift only, no update (TDR outputs unchanged).
- rsp_valid  output  1  one-cycle pulse, access complete.
- rsp_rdata  output  TDR_LEN  captured TDR contents; held until the next rsp_valid.
- ijtag_sel  output  1  segment select.
- ijtag_ce  output  1  capture enable.
- ijtag_se  output  1  shift enable.
- ijtag_ue  output  1  update enable.
- ijtag_si  output  1  scan data to the TDR.
- ijtag_so  input  1  scan data from the TDR (target retimes on the low phase).

Behaviour:
- Reset values (async on ijtag_reset low):
  - state=IDLE.
  - req_ready=0 while in reset, 1 on the first cycle after release.
  - rsp_valid=0, rsp_rdata=0.
  - ijtag_sel/ce/se/ue/si = 0, bit counter = 0.
- All ijtag_* outputs come straight from flops; no combinational decode to the pins.
- FSM: IDLE → CAPTURE → SHIFT → UPDATE → DONE → IDLE. UPDATE is skipped when req_read_only is latched.
- IDLE:
  - req_ready=1, all ijtag_* = 0.
  - On req_valid, latch req_wdata into the tx shift register and latch req_read_only, then go to CAPTURE.
- CAPTURE:
  - 1 cycle, sel=1, ce=1, se=0.
  - The TDR parallel-loads its latch values at the closing posedge.
- SHIFT:
  - Exactly TDR_LEN cycles, sel=1, se=1, si = tx[0].
  - Each posedge: tx >>= 1; rx <= {ijtag_so, rx[TDR_LEN-1:1]}; counter++.
  - The first bit sampled is TDR bit 0.
  - When the counter reaches TDR_LEN, go to UPDATE, or to DONE if read-only.
- UPDATE:
  - 1 cycle, sel=1, ue=1, se=0, ce=0.
  - The TDR loads its output latches on the negedge within this cycle.
- DONE:
  - 1 cycle, all ijtag_* = 0.
  - rsp_valid=1 and rsp_rdata=rx, both registered, then return to IDLE.
- Latency from the accepting posedge to rsp_valid high: TDR_LEN+3 cycles for a write, TDR_LEN+2 for read-only.
- Only one of ce/se/ue is ever high in a cycle. sel=0 whenever all three are 0.
- req_ready=0 in every non-IDLE state. A request held during busy is accepted only on return to IDLE, so the earliest re-accept is the cycle after DONE.
- req_wdata/req_read_only are sampled only at accept; later changes are ignored.
- Reset mid-operation: immediate return to IDLE with outputs at reset values. No rsp_valid is issued and the partial rx is discarded. The TDR is left partially shifted, but its latches are only affected if UPDATE was reached.
- ijtag_so is sampled only in SHIFT.

Decomposition:
- Shared package ijtag_drv_pkg:
  - state enum (IDLE, CAPTURE, SHIFT, UPDATE, DONE).
  - localparam defaults for TDR_LEN.
- Natural sub-module: ijtag_drv_shifter, holding the tx/rx shift registers and the bit counter with load/shift/done signals.
- The FSM stays in the top.

Test Plan (TDR_LEN=20, bench instantiates a behavioural 20-bit TDR target with low-phase so retiming):
1. Release reset, write req_wdata=0xA5A5A → rsp_valid 23 cycles after accept; rsp_rdata=0x00000; target outputs=0xA5A5A; exactly 1 ce, 20 se, 1 ue cycle.
2. Follow-up write 0x00001 → rsp_rdata=0xA5A5A; target outputs=0x00001.
3. Read-only access after 2 → rsp_rdata=0x00001 after 22 cycles; ue never asserted; target outputs remain 0x00001.
4. req_valid held high continuously with wdata 0x12345 then 0x6789A → req_ready low throughout each access; second accept is the cycle after the first rsp_valid; second rsp_rdata=0x12345.
5. Assert ijtag_reset during SHIFT bit 10 → all ijtag_* = 0 immediately; no rsp_valid; target outputs=0 (target reset); next write 0xFFFFF completes normally with rsp_rdata=0x00000.
6. Assertion check over all scenarios → ce/se/ue mutually exclusive; sel=0 when all are low; no X on ijtag_si.

Source files
------------

// File: rtl/ijtag_tdr_access_driver_pkg.sv
// Shared types for the IJTAG TDR access driver: FSM state encoding and default TDR length.
package ijtag_drv_pkg;

    localparam int TDR_LEN_DEFAULT = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SHIFT,
        ST_UPDATE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/ijtag_tdr_access_driver_if.sv
// Parallel request/response port between the test/fuse controller and the TDR access driver.
interface ijtag_tdr_access_driver_if #(
    parameter int TDR_LEN = 20
);
    logic               req_valid;
    logic               req_ready;
    logic [TDR_LEN-1:0] req_wdata;
    logic               req_read_only;
    logic               rsp_valid;
    logic [TDR_LEN-1:0] rsp_rdata;

    modport master (
        output req_valid, req_wdata, req_read_only,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_wdata, req_read_only,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ijtag_tdr_access_driver_shifter.sv
// TX/RX shift registers and bit counter for one TDR scan pass.
module ijtag_drv_shifter
    import ijtag_drv_pkg::*;
#(
    parameter int TDR_LEN = TDR_LEN_DEFAULT,
    parameter int CNT_W   = $clog2(TDR_LEN + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [TDR_LEN-1:0] wdata_i,
    input  logic               shift_i,
    input  logic               so_i,
    output logic               last_o,
    output logic               si_next_o,
    output logic [TDR_LEN-1:0] rx_o
);

    logic [TDR_LEN-1:0] tx_q, tx_d;
    logic [TDR_LEN-1:0] rx_q, rx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        tx_d  = tx_q;
        rx_d  = rx_q;
        cnt_d = cnt_q;
        if (load_i) begin
            tx_d  = wdata_i;
            rx_d  = '0;
            cnt_d = '0;
        end else if (shift_i) begin
            tx_d  = {1'b0, tx_q[TDR_LEN-1:1]};
            rx_d  = {so_i, rx_q[TDR_LEN-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_q  <= '0;
            rx_q  <= '0;
            cnt_q <= '0;
        end else begin
            tx_q  <= tx_d;
            rx_q  <= rx_d;
            cnt_q <= cnt_d;
        end
    end

    // Counter reaches TDR_LEN on the edge that closes this shift cycle.
    assign last_o    = (cnt_q == CNT_W'(TDR_LEN - 1));
    // LSB that tx will hold after this edge, so si can be registered.
    assign si_next_o = shift_i ? tx_q[1] : tx_q[0];
    assign rx_o      = rx_q;

endmodule

// File: rtl/ijtag_tdr_access_driver.sv
// IJTAG initiator: runs capture -> shift -> (update) on one TDR segment per parallel request.
module ijtag_tdr_access_driver
    import ijtag_drv_pkg::*;
#(
    parameter int TDR_LEN = TDR_LEN_DEFAULT,
    parameter int CNT_W   = $clog2(TDR_LEN + 1)
) (
    input  logic                    ijtag_tck,
    input  logic                    ijtag_reset,
    ijtag_tdr_access_driver_if.slave bus,
    output logic                    ijtag_sel,
    output logic                    ijtag_ce,
    output logic                    ijtag_se,
    output logic                    ijtag_ue,
    output logic                    ijtag_si,
    input  logic                    ijtag_so
);

    state_e             state_q, state_d;
    logic               ready_q, ready_d;
    logic               ro_q;
    logic               rsp_valid_q;
    logic [TDR_LEN-1:0] rsp_rdata_q;
    logic               sel_q, sel_d;
    logic               ce_q, ce_d;
    logic               se_q, se_d;
    logic               ue_q, ue_d;
    logic               si_q, si_d;

    logic               load;
    logic               shift;
    logic               last;
    logic               si_next;
    logic [TDR_LEN-1:0] rx;

    ijtag_drv_shifter #(
        .TDR_LEN (TDR_LEN),
        .CNT_W   (CNT_W)
    ) u_shifter (
        .clk_i     (ijtag_tck),
        .rst_ni    (ijtag_reset),
        .load_i    (load),
        .wdata_i   (bus.req_wdata),
        .shift_i   (shift),
        .so_i      (ijtag_so),
        .last_o    (last),
        .si_next_o (si_next),
        .rx_o      (rx)
    );

    // Pin values are decoded from the next state so every ijtag_* pin is a flop.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && ready_q) begin
                    load    = 1'b1;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_d = ST_SHIFT;
            ST_SHIFT: begin
                shift = 1'b1;
                if (last) state_d = ro_q ? ST_DONE : ST_UPDATE;
            end
            ST_UPDATE: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        ce_d    = (state_d == ST_CAPTURE);
        se_d    = (state_d == ST_SHIFT);
        ue_d    = (state_d == ST_UPDATE);
        sel_d   = ce_d || se_d || ue_d;
        si_d    = se_d && si_next;
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            ro_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            sel_q       <= 1'b0;
            ce_q        <= 1'b0;
            se_q        <= 1'b0;
            ue_q        <= 1'b0;
            si_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            if (load) ro_q <= bus.req_read_only;
            rsp_valid_q <= (state_q == ST_DONE);
            if (state_q == ST_DONE) rsp_rdata_q <= rx;
            sel_q       <= sel_d;
            ce_q        <= ce_d;
            se_q        <= se_d;
            ue_q        <= ue_d;
            si_q        <= si_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign ijtag_sel     = sel_q;
    assign ijtag_ce      = ce_q;
    assign ijtag_se      = se_q;
    assign ijtag_ue      = ue_q;
    assign ijtag_si      = si_q;

endmodule

// File: tb/tb_ijtag_tdr_access_driver.sv
// Bench for ijtag_tdr_access_driver: behavioural 20-bit TDR target plus a transaction-level reference model.
module tb_ijtag_tdr_access_driver;

    localparam int L = 20;

    logic tck = 1'b0;
    logic rst_n = 1'b0;
    always #5 tck = ~tck;

    ijtag_tdr_access_driver_if #(.TDR_LEN(L)) bus ();

    logic sel, ce, se, ue, si, so;

    ijtag_tdr_access_driver #(.TDR_LEN(L)) dut (
        .ijtag_tck   (tck),
        .ijtag_reset (rst_n),
        .bus         (bus),
        .ijtag_sel   (sel),
        .ijtag_ce    (ce),
        .ijtag_se    (se),
        .ijtag_ue    (ue),
        .ijtag_si    (si),
        .ijtag_so    (so)
    );

    // Behavioural TDR target: shift chain on posedge, so retimed and update latched on negedge.
    logic [L-1:0] tdr_sr, tdr_out;
    logic         tdr_so;

    always @(posedge tck or negedge rst_n) begin
        if (!rst_n)             tdr_sr <= '0;
        else if (sel && ce)     tdr_sr <= tdr_out;
        else if (sel && se)     tdr_sr <= {si, tdr_sr[L-1:1]};
    end

    always @(negedge tck or negedge rst_n) begin
        if (!rst_n) begin
            tdr_so  <= 1'b0;
            tdr_out <= '0;
        end else begin
            tdr_so <= tdr_sr[0];
            if (sel && ue) tdr_out <= tdr_sr;
        end
    end

    assign so = tdr_so;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle counters and protocol invariants, sampled mid-cycle.
    int n_ce = 0, n_se = 0, n_ue = 0, n_rsp = 0;

    always @(negedge tck) begin
        if (ce) n_ce++;
        if (se) n_se++;
        if (ue) n_ue++;
        if (bus.rsp_valid) n_rsp++;
        if (rst_n) begin
            check_eq("ctl_onehot", 32'($onehot0({ce, se, ue})), 32'd1);
            check_eq("sel_map", 32'(sel), 32'(ce | se | ue));
            check_eq("si_known", 32'($isunknown(si)), 32'd0);
        end
    end

    // Reference model: what the TDR latches hold, and the last response data.
    logic [L-1:0] mdl_out = '0;
    logic [L-1:0] last_rd = '0;

    task automatic run_access(input logic [L-1:0] wd, input logic ro, input bit keep,
                              output int acc_wait);
        int           lat;
        int           busy_ready;
        logic [L-1:0] exp_rd;
        exp_rd            = mdl_out;
        bus.req_valid     = 1'b1;
        bus.req_wdata     = wd;
        bus.req_read_only = ro;
        acc_wait          = 0;
        while (!bus.req_ready && acc_wait < 50) begin
            @(negedge tck);
            acc_wait++;
        end
        if (!bus.req_ready) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        n_ce = 0; n_se = 0; n_ue = 0;
        @(negedge tck);
        if (!keep) bus.req_valid = 1'b0;
        bus.req_wdata     = L'($urandom);
        bus.req_read_only = 1'($urandom_range(0, 1));
        lat        = 0;
        busy_ready = 0;
        while (!bus.rsp_valid && lat < 100) begin
            if (bus.req_ready) busy_ready++;
            @(negedge tck);
            lat++;
        end
        if (!ro) mdl_out = wd;
        last_rd = exp_rd;
        check_eq("latency", 32'(lat), ro ? 32'd22 : 32'd23);
        check_eq("ready_busy", 32'(busy_ready), 32'd0);
        check_eq("rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
        check_eq("ce_cycles", 32'(n_ce), 32'd1);
        check_eq("se_cycles", 32'(n_se), 32'(L));
        check_eq("ue_cycles", 32'(n_ue), ro ? 32'd0 : 32'd1);
        check_eq("tdr_out", 32'(tdr_out), 32'(mdl_out));
    endtask

    initial begin
        int w;
        bus.req_valid     = 1'b0;
        bus.req_wdata     = '0;
        bus.req_read_only = 1'b0;

        // Reset values
        repeat (2) @(negedge tck);
        check_eq("rst_pins", 32'({sel, ce, se, ue, si}), 32'd0);
        check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
        check_eq("rst_rsp", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
        rst_n = 1'b1;
        @(negedge tck);
        check_eq("ready_after_rst", 32'(bus.req_ready), 32'd1);

        // 1-3: write, follow-up write, read-only
        run_access(20'hA5A5A, 1'b0, 1'b0, w);
        @(negedge tck);
        check_eq("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
        run_access(20'h00001, 1'b0, 1'b0, w);
        @(negedge tck);
        run_access(L'($urandom), 1'b1, 1'b0, w);
        @(negedge tck);

        // 4: request held continuously across two accesses
        run_access(20'h12345, 1'b0, 1'b1, w);
        check_eq("b2b_rsp_ready", 32'({bus.rsp_valid, bus.req_ready}), 32'd3);
        run_access(20'h6789A, 1'b0, 1'b1, w);
        check_eq("b2b_accept_wait", 32'(w), 32'd0);
        bus.req_valid = 1'b0;
        @(negedge tck);

        // 5: reset during shift bit 10
        bus.req_valid     = 1'b1;
        bus.req_wdata     = L'($urandom);
        bus.req_read_only = 1'b0;
        @(negedge tck);
        bus.req_valid = 1'b0;
        repeat (11) @(negedge tck);
        check_eq("mid_in_shift", 32'(se), 32'd1);
        n_rsp = 0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_pins", 32'({sel, ce, se, ue, si}), 32'd0);
        check_eq("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        check_eq("mid_rst_tdr", 32'(tdr_out), 32'd0);
        mdl_out = '0;
        last_rd = '0;
        repeat (2) @(negedge tck);
        rst_n = 1'b1;
        repeat (25) @(negedge tck);
        check_eq("mid_rst_no_rsp", 32'(n_rsp), 32'd0);
        run_access(20'hFFFFF, 1'b0, 1'b0, w);

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(1, 4);
            for (int g = 0; g < gap; g++) begin
                @(negedge tck);
                check_eq("rdata_hold", 32'(bus.rsp_rdata), 32'(last_rd));
            end
            check_eq("rsp_idle", 32'(bus.rsp_valid), 32'd0);
            run_access(L'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0, w);
        end

        @(negedge tck);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
